// File: rtl/serial_rx_controller_if.sv
// Control/handshake bundle between serial_rx_controller, its shift-register/bit-counter
// datapath and the byte consumer. master = controller side, slave = environment side.
interface serial_rx_controller_if;
  logic serI;
  logic Co;
  logic byte_ready;
  logic Init_reg;
  logic Init_cnt;
  logic en_reg;
  logic Inc_cnt;
  logic byte_valid;
  logic frame_err;
  logic parity_err;
  logic busy;

  modport master (
    input  serI, Co, byte_ready,
    output Init_reg, Init_cnt, en_reg, Inc_cnt, byte_valid, frame_err, parity_err, busy
  );

  modport slave (
    output serI, Co, byte_ready,
    input  Init_reg, Init_cnt, en_reg, Inc_cnt, byte_valid, frame_err, parity_err, busy
  );
endinterface

// File: rtl/serial_rx_controller.sv
// Receive-path control FSM: start-bit detect, 8 data-bit shift, stop-bit check, valid/ready hand-off.
// Optional parity stage is compiled in with `define RX_PARITY_CHECK_EN.
module serial_rx_controller #(
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input logic                   clk,
  input logic                   rst,
  serial_rx_controller_if.master rx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    STOP1 = 3'd2,
    STOP2 = 3'd3,
    DONE  = 3'd4,
    BREAK = 3'd5
`ifdef RX_PARITY_CHECK_EN
    , PARITY = 3'd6
`endif
  } state_e;

  state_e state;
  state_e nxt;
  logic   frame_hit;
  logic   parity_hit;

  logic init_q;
  logic shift_q;
  logic valid_q;
  logic busy_q;
  logic frame_q;

`ifdef RX_PARITY_CHECK_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic par_acc;
  logic parity_q;
`endif

  // NOTE: every combinational output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    nxt        = state;
    frame_hit  = 1'b0;
    parity_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx.serI) nxt = SHIFT;
      end
      SHIFT: begin
        // Co marks the cycle in which the 8th data bit is being shifted in.
        if (rx.Co) begin
`ifdef RX_PARITY_CHECK_EN
          nxt = PARITY;
`else
          nxt = STOP1;
`endif
        end
      end
`ifdef RX_PARITY_CHECK_EN
      PARITY: begin
        if ((par_acc ^ rx.serI) != PAR_SENSE) begin
          parity_hit = 1'b1;
          if (rx.serI) nxt = IDLE;
          else         nxt = BREAK;
        end else begin
          nxt = STOP1;
        end
      end
`endif
      STOP1, STOP2: begin
        if (!rx.serI) begin
          frame_hit = 1'b1;
          nxt       = BREAK;
        end else if (state == STOP1 && STOP_BITS == 2) begin
          nxt = STOP2;
        end else begin
          nxt = DONE;
        end
      end
      DONE: begin
        if (rx.byte_ready) nxt = IDLE;
      end
      BREAK: begin
        // A line held low after an error must return high before a new start bit counts.
        if (rx.serI) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each one is a pure function of the
  // state register in the cycle it is visible; the error pulses ride along for one cycle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      init_q  <= 1'b1;
      shift_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state   <= nxt;
      init_q  <= (nxt == IDLE);
      shift_q <= (nxt == SHIFT);
      valid_q <= (nxt == DONE);
      busy_q  <= (nxt != IDLE);
      frame_q <= frame_hit;
    end
  end

`ifdef RX_PARITY_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_acc  <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_hit;
      if (state == IDLE)       par_acc <= 1'b0;
      else if (state == SHIFT) par_acc <= par_acc ^ rx.serI;
    end
  end

  assign rx.parity_err = parity_q;
`else
  assign rx.parity_err = 1'b0;
`endif

  assign rx.Init_reg   = init_q;
  assign rx.Init_cnt   = init_q;
  assign rx.en_reg     = shift_q;
  assign rx.Inc_cnt    = shift_q;
  assign rx.byte_valid = valid_q;
  assign rx.busy       = busy_q;
  assign rx.frame_err  = frame_q;

  // Clearing and shifting/counting the datapath in the same cycle would corrupt the byte.
  a_no_clear_and_shift : assert property (@(posedge clk) disable iff (rst)
    !((rx.Init_reg || rx.Init_cnt) && (rx.en_reg || rx.Inc_cnt)));

  a_legal_params : assert property (@(posedge clk)
    (STOP_BITS == 1 || STOP_BITS == 2) && (PARITY_ODD == 0 || PARITY_ODD == 1));

endmodule

// File: tb/tb_serial_rx_controller.sv
// Scoreboard bench for serial_rx_controller with a behavioural 8-bit shift-register/counter datapath.
// Parity cases run when RX_PARITY_CHECK_EN is defined.
module tb_serial_rx_controller;

  typedef enum logic [1:0] {EV_BYTE, EV_FRAME, EV_PARITY} ev_e;
  typedef struct packed {
    ev_e        kind;
    logic [7:0] data;
  } ev_t;

`ifdef RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam bit PODD = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_rx_controller_if rx();

  serial_rx_controller #(.STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx.master)
  );

  // Datapath model: LSB-first shift register and 3-bit bit counter.
  logic [7:0] dp_reg;
  logic [2:0] dp_cnt;
  always_ff @(posedge clk) begin
    if (rx.Init_reg)    dp_reg <= '0;
    else if (rx.en_reg) dp_reg <= {rx.serI, dp_reg[7:1]};
    if (rx.Init_cnt)     dp_cnt <= '0;
    else if (rx.Inc_cnt) dp_cnt <= dp_cnt + 3'd1;
  end
  assign rx.Co = (dp_cnt == 3'd7);

  int  n_vec = 0;
  int  n_bad = 0;
  ev_t sb[$];
  int  en_seen, co_seen, valid_seen, ferr_seen, perr_seen;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic ev_t mk(input ev_e k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    return e;
  endfunction

  function automatic logic good_par(input logic [7:0] b);
    return (^b) ^ PODD;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v);
    rx.serI = v;
    tick();
    if (rx.en_reg)     en_seen++;
    if (rx.Co)         co_seen++;
    if (rx.byte_valid) valid_seen++;
    if (rx.frame_err)  ferr_seen++;
    if (rx.parity_err) perr_seen++;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    en_seen = 0; co_seen = 0; valid_seen = 0; ferr_seen = 0; perr_seen = 0;
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(b[i]);
    if (PAR_EN) drive(par);
    drive(stop);
  endtask

  task automatic observe(input ev_e kind, input logic [7:0] data);
    ev_t exp;
    check("sb_event_expected", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      check("sb_kind", 32'(kind), 32'(exp.kind));
      if (exp.kind == EV_BYTE) check("sb_byte", 32'(data), 32'(exp.data));
    end
  endtask

  // Monitor: consumes every handshake and error pulse the DUT presents.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rx.byte_valid && rx.byte_ready) observe(EV_BYTE, dp_reg);
        if (rx.frame_err)                   observe(EV_FRAME, 8'h00);
        if (rx.parity_err)                  observe(EV_PARITY, 8'h00);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  logic [7:0] pats [3];

  initial begin
    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h5A;
    rx.serI = 1'b1;
    rx.byte_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_init_reg",   32'(rx.Init_reg),   32'd1);
    check("rst_init_cnt",   32'(rx.Init_cnt),   32'd1);
    check("rst_en_reg",     32'(rx.en_reg),     32'd0);
    check("rst_inc_cnt",    32'(rx.Inc_cnt),    32'd0);
    check("rst_byte_valid", 32'(rx.byte_valid), 32'd0);
    check("rst_frame_err",  32'(rx.frame_err),  32'd0);
    check("rst_parity_err", 32'(rx.parity_err), 32'd0);
    check("rst_busy",       32'(rx.busy),       32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_init_reg", 32'(rx.Init_reg),   32'd1);
      check("idle_busy",     32'(rx.busy),       32'd0);
      check("idle_valid",    32'(rx.byte_valid), 32'd0);
    end

    // 0xA5 with consumer ready: valid for exactly one cycle after the stop bit.
    sb.push_back(mk(EV_BYTE, 8'hA5));
    send_frame(8'hA5, good_par(8'hA5), 1'b1);
    check("a5_valid_after_stop", 32'(rx.byte_valid), 32'd1);
    check("a5_valid_not_early",  32'(valid_seen),    32'd1);
    check("a5_en_cycles",        32'(en_seen),       32'd8);
    check("a5_co_cycles",        32'(co_seen),       32'd1);
    check("a5_dp_reg",           32'(dp_reg),        32'hA5);
    rx.serI = 1'b1;
    tick();
    check("a5_valid_one_cycle", 32'(rx.byte_valid), 32'd0);
    check("a5_back_idle",       32'(rx.busy),       32'd0);

    // Backpressure: consumer stalls 5 cycles while the line toggles.
    rx.byte_ready = 1'b0;
    sb.push_back(mk(EV_BYTE, 8'hA5));
    send_frame(8'hA5, good_par(8'hA5), 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", 32'(rx.byte_valid), 32'd1);
      check("bp_en_low",     32'(rx.en_reg),     32'd0);
      rx.serI = i[0];
      tick();
    end
    rx.byte_ready = 1'b1;
    rx.serI = 1'b1;
    check("bp_valid_6th", 32'(rx.byte_valid), 32'd1);
    check("bp_data_held", 32'(dp_reg),        32'hA5);
    tick();
    check("bp_released", 32'(rx.byte_valid), 32'd0);

    // Framing error: bad stop bit, line held low, then released.
    sb.push_back(mk(EV_FRAME, 8'h00));
    send_frame(8'h3C, good_par(8'h3C), 1'b0);
    check("fe_pulse",    32'(rx.frame_err),  32'd1);
    check("fe_no_valid", 32'(rx.byte_valid), 32'd0);
    check("fe_busy",     32'(rx.busy),       32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0);
      check("fe_break_busy",  32'(rx.busy),      32'd1);
      check("fe_pulse_once",  32'(rx.frame_err), 32'd0);
      check("fe_break_no_en", 32'(rx.en_reg),    32'd0);
    end
    drive(1'b1);
    check("fe_idle",     32'(rx.busy),       32'd0);
    check("fe_idle_clr", 32'(rx.Init_reg),   32'd1);
    check("fe_no_valid_end", 32'(valid_seen), 32'd0);

    // Reset asserted while data bit 4 is on the line.
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1);
    rx.serI = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_init_reg", 32'(rx.Init_reg), 32'd1);
    check("mid_rst_init_cnt", 32'(rx.Init_cnt), 32'd1);
    check("mid_rst_en_reg",   32'(rx.en_reg),   32'd0);
    check("mid_rst_inc_cnt",  32'(rx.Inc_cnt),  32'd0);
    check("mid_rst_busy",     32'(rx.busy),     32'd0);
    rx.serI = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    sb.push_back(mk(EV_BYTE, 8'h81));
    send_frame(8'h81, good_par(8'h81), 1'b1);
    check("post_rst_valid", 32'(rx.byte_valid), 32'd1);
    check("post_rst_data",  32'(dp_reg),        32'h81);
    rx.serI = 1'b1;
    tick();

    // Back-to-back boundary patterns.
    for (int p = 0; p < 3; p++) begin
      sb.push_back(mk(EV_BYTE, pats[p]));
      send_frame(pats[p], good_par(pats[p]), 1'b1);
      check("pat_valid",  32'(rx.byte_valid), 32'd1);
      check("pat_en_cyc", 32'(en_seen),       32'd8);
      rx.serI = 1'b1;
      tick();
    end

`ifdef RX_PARITY_CHECK_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1.
    sb.push_back(mk(EV_BYTE, 8'h07));
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_ok_valid",     32'(rx.byte_valid), 32'd1);
    check("par_ok_not_early", 32'(valid_seen),    32'd1);
    check("par_ok_no_err",    32'(perr_seen),     32'd0);
    rx.serI = 1'b1;
    tick();
    sb.push_back(mk(EV_PARITY, 8'h00));
    send_frame(8'h07, 1'b0, 1'b1);
    check("par_bad_pulse",    32'(perr_seen),     32'd1);
    check("par_bad_no_valid", 32'(valid_seen),    32'd0);
    check("par_bad_idle",     32'(rx.busy),       32'd0);
    rx.serI = 1'b1;
    tick();
`endif

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_rx_controller.md
Name: serial_rx_controller

Overview:
- Control FSM for the serial receive path; sits directly upstream of the 8-bit shift-register/bit-counter datapath.
- Watches the serial line serI for a start bit and drives the datapath's register-clear, shift-enable, counter-clear and counter-increment controls.
- Uses the datapath's carry-out Co to detect the 8th data bit, then checks the stop bit(s).
- Presents a valid/ready handshake to the byte consumer; the datapath holds reg_out stable while byte_valid is high.

Parameters:
- STOP_BITS, 1, number of stop-bit cycles checked after the data bits (legal values 1 or 2).
- PARITY_ODD, 0, parity sense when parity checking is compiled in: 0 = even, 1 = odd.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- serI  input  1  serial line, one bit per clk; idles high; LSB-first framing.
- Co  input  1  datapath counter carry-out; high when the bit count is 7.
- byte_ready  input  1  consumer accepts the byte held in the datapath.
- Init_reg  output  1  clear datapath shift register.
- Init_cnt  output  1  clear datapath bit counter.
- en_reg  output  1  shift serI into datapath register.
- Inc_cnt  output  1  increment datapath bit counter.
- byte_valid  output  1  datapath reg_out holds a complete, good byte.
- frame_err  output  1  one-cycle pulse: bad stop bit.
- parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 without the macro.
- busy  output  1  high in every state except IDLE.

Behaviour:
- All control outputs are Moore, decoded from the state register only.
- States:
  - IDLE: Init_reg=1, Init_cnt=1. If serI==0 (start bit), go to SHIFT.
  - SHIFT: en_reg=1, Inc_cnt=1. If Co==1, this cycle shifts the 8th bit; go to PARITY if compiled in, else STOP1.
  - STOP1: samples serI. If 0, pulse frame_err and go to BREAK. If 1, go to STOP2 when STOP_BITS==2, else DONE.
  - STOP2: same check as STOP1; if serI==1, go to DONE.
  - DONE: byte_valid=1; all datapath controls 0, so reg_out holds. If byte_ready==1, go to IDLE on the next edge.
  - BREAK: go to IDLE once serI==1. Prevents a held-low line from being taken as a new start bit.
- Timing: start bit sampled at edge t; data bits d0..d7 are on serI in cycles t+1..t+8; Co is high in cycle t+8; stop bit in t+9 (STOP_BITS=1); byte_valid rises at t+10.
- Minimum handshake: byte_valid high for 1 cycle when byte_ready is already high.
- serI activity while in DONE is ignored; there is no overrun detection.
- A byte is not delivered after frame_err or parity_err; the datapath is cleared on return to IDLE.
- Reset:
  - Asynchronous; forces IDLE at any point, including mid-frame or during DONE.
  - Output values during and after reset: Init_reg=1, Init_cnt=1, en_reg=0, Inc_cnt=0, byte_valid=0, frame_err=0, parity_err=0, busy=0.
- The block never asserts Init_* and en_reg/Inc_cnt in the same cycle.

Optional Feature:
- Macro: RX_PARITY_CHECK_EN.
- With the macro:
  - A running XOR of serI is cleared in IDLE and updated in every SHIFT cycle.
  - A PARITY state follows SHIFT and samples one parity bit.
  - Mismatch against PARITY_ODD pulses parity_err for 1 cycle and goes to BREAK if serI==0, else IDLE.
  - Match goes to STOP1.
  - byte_valid therefore rises one cycle later (t+11).
- Without the macro: no PARITY state and no XOR register; parity_err is constant 0.

Test Plan:
- Reset then idle: serI=1, rst pulse -> Init_reg=Init_cnt=1, busy=0, byte_valid=0 indefinitely.
- Byte 0xA5, STOP_BITS=1, byte_ready=1:
  - serI = 0,1,0,1,0,0,1,0,1,1.
  - en_reg and Inc_cnt are high for exactly 8 cycles; Co is high in the 8th.
  - byte_valid is high one cycle at t+10; the datapath reads 0xA5.
- Backpressure: same 0xA5 frame with byte_ready=0 for 5 cycles -> byte_valid stays high 6 cycles, en_reg stays 0, and serI toggling is ignored.
- Framing error: send 0x3C with stop bit 0, then serI=0 for 4 cycles, then 1 -> frame_err one-cycle pulse, no byte_valid, state BREAK until serI=1, then IDLE.
- Reset mid-frame: rst asserted at data bit 4 -> immediate IDLE outputs; the next full frame 0x81 is received correctly.
- Parity (RX_PARITY_CHECK_EN, PARITY_ODD=0):
  - 0x07 with parity 1, then stop 1 -> byte_valid at t+11.
  - Same frame with parity 0 -> parity_err pulse, no byte_valid.
